// File: rtl/clock_divider_prog.sv
// Programmable clock divider: square-wave clock_out plus a one-cycle tick per period.
// Divisor changes are staged in a pending register and take effect only at a period boundary or restart.
module clock_divider_prog #(
    parameter int          WIDTH       = 28,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             clock_out,
    output logic             tick,
    output logic             load_err,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] DEFAULT_DIV_W = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_DIV       = WIDTH'(2);

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] pending;
    logic             pending_valid;

    logic [WIDTH-1:0] counter_next;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] half_next;
    logic [WIDTH-1:0] pending_next;
    logic             pending_valid_next;
    logic             clock_out_next;
    logic             tick_next;
    logic             load_err_next;
    logic             wrap;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        counter_next       = counter;
        div_next           = div_active;
        half_next          = div_active >> 1;
        pending_next       = pending;
        pending_valid_next = pending_valid;
        clock_out_next     = clock_out;
        tick_next          = 1'b0;
        load_err_next      = 1'b0;
        wrap               = (counter == div_active - WIDTH'(1));

        if (restart) begin
            counter_next   = '0;
            clock_out_next = 1'b0;
            if (pending_valid) begin
                div_next           = pending;
                pending_valid_next = 1'b0;
            end
        end else if (enable) begin
            if (wrap) begin
                counter_next = '0;
                if (pending_valid) begin
                    div_next           = pending;
                    pending_valid_next = 1'b0;
                end
            end else begin
                counter_next = counter + WIDTH'(1);
            end
            // Half is taken from the divisor of the period being entered, so a switch never leaves a runt.
            half_next      = div_next >> 1;
            clock_out_next = (counter_next < half_next);
            tick_next      = wrap;
        end

        // A load after the boundary logic above: a same-cycle wrap consumes the old pending value first.
        if (div_load) begin
            if (div_value >= MIN_DIV) begin
                pending_next       = div_value;
                pending_valid_next = 1'b1;
            end else begin
                load_err_next = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            counter       <= '0;
            clock_out     <= 1'b0;
            tick          <= 1'b0;
            load_err      <= 1'b0;
            div_active    <= DEFAULT_DIV_W;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            counter       <= counter_next;
            clock_out     <= clock_out_next;
            tick          <= tick_next;
            load_err      <= load_err_next;
            div_active    <= div_next;
            pending       <= pending_next;
            pending_valid <= pending_valid_next;
        end
    end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: divisor 4 and 5 instances, staged loads, freeze, restart and reset.
module tb_clock_divider_prog;

    localparam int WIDTH = 28;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             restart;
    logic             div_load;
    logic [WIDTH-1:0] div_value;

    logic             clock_out,  tick,  load_err;
    logic [WIDTH-1:0] div_active;
    logic             clock_out5, tick5, load_err5;
    logic [WIDTH-1:0] div_active5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) u_div4 (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .restart    (restart),
        .div_load   (div_load),
        .div_value  (div_value),
        .clock_out  (clock_out),
        .tick       (tick),
        .load_err   (load_err),
        .div_active (div_active)
    );

    clock_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(5)) u_div5 (
        .clock_in   (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .restart    (restart),
        .div_load   (div_load),
        .div_value  (div_value),
        .clock_out  (clock_out5),
        .tick       (tick5),
        .load_err   (load_err5),
        .div_active (div_active5)
    );

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; div_load = 1'b0; div_value = '0;
        step();
        step();
        checks++;
        if ({clock_out, tick, load_err} !== 3'b000 || div_active !== 28'd4) begin
            failures++;
            $display("FAIL reset_div4: co/tick/err=%b%b%b div=%0d, required 000 div=4",
                     clock_out, tick, load_err, div_active);
        end
        checks++;
        if ({clock_out5, tick5, load_err5} !== 3'b000 || div_active5 !== 28'd5) begin
            failures++;
            $display("FAIL reset_div5: co/tick/err=%b%b%b div=%0d, required 000 div=5",
                     clock_out5, tick5, load_err5, div_active5);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_default_div();
        logic [11:0] co4 = 12'b100110011001;
        logic [11:0] t4  = 12'b000100010001;
        logic [11:0] co5 = 12'b100011000110;
        logic [11:0] t5  = 12'b000010000100;
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({clock_out, tick} !== {co4[11-i], t4[11-i]} || div_active !== 28'd4) begin
                failures++;
                $display("FAIL div4_edge%0d: co/tick=%b%b div=%0d, required %b%b div=4",
                         i + 1, clock_out, tick, div_active, co4[11-i], t4[11-i]);
            end
            checks++;
            if ({clock_out5, tick5} !== {co5[11-i], t5[11-i]} || div_active5 !== 28'd5) begin
                failures++;
                $display("FAIL div5_edge%0d: co/tick=%b%b div=%0d, required %b%b div=5",
                         i + 1, clock_out5, tick5, div_active5, co5[11-i], t5[11-i]);
            end
        end
    endtask

    task automatic test_load_change();
        logic [8:0] co = 9'b001110001;
        logic [8:0] tk = 9'b001000001;
        logic [WIDTH-1:0] exp_div;
        step();                                  // counter now 1
        div_load = 1'b1; div_value = 28'd6;
        for (int i = 0; i < 9; i++) begin
            step();
            div_load = 1'b0;
            exp_div = (i < 2) ? 28'd4 : 28'd6;
            checks++;
            if ({clock_out, tick} !== {co[8-i], tk[8-i]} || div_active !== exp_div) begin
                failures++;
                $display("FAIL load6_edge%0d: co/tick=%b%b div=%0d, required %b%b div=%0d",
                         i, clock_out, tick, div_active, co[8-i], tk[8-i], exp_div);
            end
        end
        // Rejected load: divisor 1.
        div_load = 1'b1; div_value = 28'd1;
        step();
        div_load = 1'b0;
        checks++;
        if (load_err !== 1'b1 || div_active !== 28'd6 || clock_out !== 1'b1) begin
            failures++;
            $display("FAIL load_err_set: err=%b div=%0d co=%b, required err=1 div=6 co=1",
                     load_err, div_active, clock_out);
        end
        step();
        checks++;
        if (load_err !== 1'b0 || div_active !== 28'd6) begin
            failures++;
            $display("FAIL load_err_clear: err=%b div=%0d, required err=0 div=6", load_err, div_active);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (tick !== 1'b1 || div_active !== 28'd6 || clock_out !== 1'b1) begin
            failures++;
            $display("FAIL load_err_wrap: tick=%b div=%0d co=%b, required tick=1 div=6 co=1",
                     tick, div_active, clock_out);
        end
    endtask

    task automatic test_load_at_wrap();
        logic [11:0] co = 12'b100111100001;
        logic [11:0] tk = 12'b000100000001;
        logic [WIDTH-1:0] exp_div;
        // Return to divisor 4 first.
        div_load = 1'b1; div_value = 28'd4;
        step();
        div_load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (tick !== 1'b1 || div_active !== 28'd4) begin
            failures++;
            $display("FAIL back_to_4: tick=%b div=%0d, required tick=1 div=4", tick, div_active);
        end
        for (int i = 0; i < 3; i++) step();      // counter now 3
        div_load = 1'b1; div_value = 28'd8;
        step();
        div_load = 1'b0;
        checks++;
        if ({clock_out, tick} !== 2'b11 || div_active !== 28'd4) begin
            failures++;
            $display("FAIL wrap_same_cycle: co/tick=%b%b div=%0d, required 11 div=4",
                     clock_out, tick, div_active);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            exp_div = (i < 3) ? 28'd4 : 28'd8;
            checks++;
            if ({clock_out, tick} !== {co[11-i], tk[11-i]} || div_active !== exp_div) begin
                failures++;
                $display("FAIL load8_edge%0d: co/tick=%b%b div=%0d, required %b%b div=%0d",
                         i + 1, clock_out, tick, div_active, co[11-i], tk[11-i], exp_div);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [5:0] co = 6'b100001;
        logic [5:0] tk = 6'b000001;
        step();
        step();                                  // counter 2 of 8, clock_out high
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({clock_out, tick} !== 2'b10 || div_active !== 28'd8) begin
                failures++;
                $display("FAIL freeze_edge%0d: co/tick=%b%b div=%0d, required 10 div=8",
                         i, clock_out, tick, div_active);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({clock_out, tick} !== {co[5-i], tk[5-i]} || div_active !== 28'd8) begin
                failures++;
                $display("FAIL resume_edge%0d: co/tick=%b%b div=%0d, required %b%b div=8",
                         i, clock_out, tick, div_active, co[5-i], tk[5-i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [9:0] co = 10'b1111000001;
        logic [9:0] tk = 10'b0000000001;
        for (int i = 0; i < 3; i++) step();      // counter 3 of 8
        enable = 1'b0; div_load = 1'b1; div_value = 28'd10;
        step();
        div_load = 1'b0;
        checks++;
        if ({clock_out, tick} !== 2'b10 || div_active !== 28'd8) begin
            failures++;
            $display("FAIL load_disabled: co/tick=%b%b div=%0d, required 10 div=8",
                     clock_out, tick, div_active);
        end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++;
        if ({clock_out, tick} !== 2'b00 || div_active !== 28'd10) begin
            failures++;
            $display("FAIL restart: co/tick=%b%b div=%0d, required 00 div=10",
                     clock_out, tick, div_active);
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({clock_out, tick} !== {co[9-i], tk[9-i]} || div_active !== 28'd10) begin
                failures++;
                $display("FAIL after_restart_edge%0d: co/tick=%b%b div=%0d, required %b%b div=10",
                         i + 1, clock_out, tick, div_active, co[9-i], tk[9-i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] co = 8'b10011001;
        logic [7:0] tk = 8'b00010001;
        div_load = 1'b1; div_value = 28'd6;
        step();
        div_load = 1'b0;
        step();                                  // counter 2 of 10, pending 6 waiting
        reset_n = 1'b0;
        #3;
        checks++;
        if (clock_out !== 1'b1 || div_active !== 28'd10) begin
            failures++;
            $display("FAIL reset_between_edges: co=%b div=%0d, required co=1 div=10",
                     clock_out, div_active);
        end
        step();
        checks++;
        if ({clock_out, tick, load_err} !== 3'b000 || div_active !== 28'd4) begin
            failures++;
            $display("FAIL reset_mid: co/tick/err=%b%b%b div=%0d, required 000 div=4",
                     clock_out, tick, load_err, div_active);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({clock_out, tick} !== {co[7-i], tk[7-i]} || div_active !== 28'd4) begin
                failures++;
                $display("FAIL post_reset_edge%0d: co/tick=%b%b div=%0d, required %b%b div=4",
                         i + 1, clock_out, tick, div_active, co[7-i], tk[7-i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_load_change();
        test_load_at_wrap();
        test_enable_freeze();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Programmable, parametrised clock-enable/divider generator.
- Produces a square-wave `clock_out` and a one-cycle `tick` strobe from `clock_in`. The divisor is changeable at run time and takes effect glitch-free at the period boundary.
- Adds enable, phase restart and synchronous active-low reset. Feeds the up/down counter and display blocks as their slow time base.

Parameters:
- WIDTH, 28, width of counter and divisor.
- DEFAULT_DIV, 50000000, divisor loaded at reset (1 Hz from 50 MHz). Must be >= 2 and < 2^WIDTH.

Ports:
- clock_in  input  1  system clock, all logic on rising edge
- reset_n  input  1  synchronous active-low reset
- enable  input  1  counting enable; low = freeze
- restart  input  1  synchronous phase restart pulse
- div_load  input  1  request to load div_value
- div_value  input  WIDTH  new divisor, valid values >= 2
- clock_out  output  1  divided square wave, registered
- tick  output  1  one-cycle pulse per period, registered
- load_err  output  1  one-cycle pulse: rejected load
- div_active  output  WIDTH  divisor currently in use

Behaviour:
- Clock and reset: one clock (`clock_in`). Reset is synchronous and active-low (`reset_n`), sampled on the rising edge of `clock_in`; it has priority over all other inputs.
- Reset values: counter=0, clock_out=0, tick=0, load_err=0, div_active=DEFAULT_DIV, pending_valid=0.
- Internal state: counter[WIDTH-1:0], div_active, pending[WIDTH-1:0], pending_valid. half = div_active>>1.
- Counting (enable=1, restart=0):
  - counter_next = (counter==div_active-1) ? 0 : counter+1.
  - clock_out <= (counter_next < half_next).
  - tick <= (counter==div_active-1).
  - Result: period = D cycles; clock_out high floor(D/2) cycles, low ceil(D/2) cycles. tick is high in the same cycle clock_out rises. Latency is 0 cycles relative to the counter (outputs registered alongside it).
- Wrap with pending_valid=1: div_active <= pending, pending_valid <= 0, counter <= 0. half_next is computed from the new divisor, so the new period starts cleanly with no runt pulse.
- div_load=1:
  - div_value >= 2: pending <= div_value, pending_valid <= 1. A second load before the wrap overwrites pending (last one wins).
  - div_value < 2: pending is unchanged; load_err=1 for exactly one cycle.
  - Loads are accepted regardless of enable.
- Load in the same cycle as a wrap: the wrap uses the old pending state. The new value is applied at the next wrap, not this one.
- enable=0: counter, clock_out and div_active hold; tick=0; loads are still captured into pending.
- restart=1 (overrides enable):
  - counter<=0, clock_out<=0, tick<=0.
  - If pending_valid, the pending value is applied immediately.
  - Counting resumes on the next enabled edge exactly as after reset.
- Reset mid-period: all state returns to reset values on that edge; any pending load is discarded.
- Arithmetic: unsigned, WIDTH bits. div_active-1 never underflows because divisor >= 2 is enforced.

Test Plan:
- Reset, then DEFAULT_DIV overridden to 4 (parameter), enable=1 for 12 cycles -> counter 1,2,3,0,...; clock_out 1,0,0,1,1,0,0,1...; tick=1 on edges 4, 8, 12; div_active=4.
- DEFAULT_DIV=5, run 10 cycles -> clock_out high 2 cycles, low 3 per period; tick every 5th edge.
- D=4; pulse div_load with div_value=6 at counter=1 -> current period finishes at 4 cycles; div_active=6 from the wrap edge; next period is 6 cycles (3 high/3 low), no runt pulse. Load of div_value=1 -> load_err one cycle, div_active unchanged.
- D=4, div_load=8 in the same cycle as counter==3 -> that wrap keeps D=4; the following wrap switches to 8.
- enable=0 for 5 cycles mid-period -> counter/clock_out frozen, tick=0; resumes from the same count. restart with a pending value of 10 -> counter=0, clock_out=0, div_active=10 next cycle.
- reset_n=0 for one edge mid-period with pending_valid=1 -> all outputs reset, div_active=DEFAULT_DIV, pending discarded; reset_n asserted between edges has no effect until the next rising edge.
